// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle shared by the UART bridge (master) and register endpoints (slave).
interface axi4_lite_if;
    // Every channel uses strict valid/ready: a beat transfers on a rising clk edge where both
    // are high, and a source holding valid keeps its payload stable until that edge.
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register bank responder: NUM_REGS x 32-bit registers, independent AW/W, byte strobes.
// Optional AXI_REG_SLAVE_DECERR_EN: out-of-range accesses get SLVERR instead of aliasing.
module axi4_lite_reg_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          NUM_REGS  = 16,
    parameter int          IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    axi4_lite_if.slave               axi,
    output logic [32*NUM_REGS-1:0]   reg_out,
    output logic                     reg_wr_pulse,
    output logic [IDX_W-1:0]         reg_wr_index
);

`ifdef AXI_REG_SLAVE_DECERR_EN
    localparam bit DECERR_EN = 1'b1;
`else
    localparam bit DECERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [31:0] regs [NUM_REGS];
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic [1:0]  bresp_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        commit;

    logic [31:0]      commit_addr;
    logic [31:0]      commit_data;
    logic [3:0]       commit_strb;
    logic [IDX_W-1:0] commit_idx;
    logic             commit_ok;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_ok;
    logic             unused_prot;

    // Without the range check the word index simply wraps modulo NUM_REGS.
    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] addr);
        logic [31:0] off;
        logic [29:0] word;
        off  = addr - BASE_ADDR;
        word = off[31:2];
        return IDX_W'(word % 30'(NUM_REGS));
    endfunction

    function automatic logic addr_ok(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return !DECERR_EN || ((addr >= BASE_ADDR) && (off[31:2] < 30'(NUM_REGS)));
    endfunction

    // The channel completing on the commit edge comes straight from the bus, the other from its latch.
    assign commit_addr = (w_state == W_HAVE_A) ? aw_addr_q : axi.awaddr;
    assign commit_data = (w_state == W_HAVE_D) ? w_data_q  : axi.wdata;
    assign commit_strb = (w_state == W_HAVE_D) ? w_strb_q  : axi.wstrb;
    assign commit_idx  = idx_of(commit_addr);
    assign commit_ok   = addr_ok(commit_addr);
    assign rd_idx      = idx_of(axi.araddr);
    assign rd_ok       = addr_ok(axi.araddr);
    assign unused_prot = ^{axi.awprot, axi.arprot};

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Readies depend on state only, so no valid-to-ready combinational path exists.
    always_comb begin
        w_next      = w_state;
        commit      = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                axi.awready = 1'b1;
                axi.wready  = 1'b1;
                if (axi.awvalid && axi.wvalid) begin
                    w_next = W_RESP;
                    commit = 1'b1;
                end else if (axi.awvalid) begin
                    w_next = W_HAVE_A;
                end else if (axi.wvalid) begin
                    w_next = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                axi.wready = 1'b1;
                if (axi.wvalid) begin
                    w_next = W_RESP;
                    commit = 1'b1;
                end
            end
            W_HAVE_D: begin
                axi.awready = 1'b1;
                if (axi.awvalid) begin
                    w_next = W_RESP;
                    commit = 1'b1;
                end
            end
            W_RESP: begin
                axi.bvalid = 1'b1;
                if (axi.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next      = r_state;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                axi.arready = 1'b1;
                if (axi.arvalid) r_next = R_RESP;
            end
            R_RESP: begin
                axi.rvalid = 1'b1;
                if (axi.rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if ((w_state == W_IDLE || w_state == W_HAVE_D) && axi.awvalid) aw_addr_q <= axi.awaddr;
            if ((w_state == W_IDLE || w_state == W_HAVE_A) && axi.wvalid) begin
                w_data_q <= axi.wdata;
                w_strb_q <= axi.wstrb;
            end
        end
    end

    // Read capture uses the pre-edge register value, so a same-edge write is not visible yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            bresp_q      <= 2'b00;
            rdata_q      <= '0;
            rresp_q      <= 2'b00;
            reg_wr_pulse <= 1'b0;
            reg_wr_index <= '0;
        end else begin
            reg_wr_pulse <= commit && commit_ok;
            if (commit) begin
                bresp_q <= commit_ok ? 2'b00 : 2'b10;
                if (commit_ok) begin
                    reg_wr_index <= commit_idx;
                    for (int k = 0; k < 4; k++)
                        if (commit_strb[k]) regs[commit_idx][8*k +: 8] <= commit_data[8*k +: 8];
                end
            end
            if (r_state == R_IDLE && axi.arvalid) begin
                rdata_q <= rd_ok ? regs[rd_idx] : 32'h0;
                rresp_q <= rd_ok ? 2'b00 : 2'b10;
            end
        end
    end

    assign axi.bresp = bresp_q;
    assign axi.rdata = rdata_q;
    assign axi.rresp = rresp_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[32*g +: 32] = regs[g];
    end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave (NUM_REGS=16, BASE_ADDR=0x1000).
module tb_axi4_lite_reg_slave;
  localparam int NUM_REGS = 16;
  localparam int IDX_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [32*NUM_REGS-1:0] reg_out;
  logic reg_wr_pulse;
  logic [IDX_W-1:0] reg_wr_index;
  int checks = 0;
  int failures = 0;

  axi4_lite_if axi ();

  axi4_lite_reg_slave #(.BASE_ADDR(32'h0000_1000), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk),
    .rst(rst),
    .axi(axi),
    .reg_out(reg_out),
    .reg_wr_pulse(reg_wr_pulse),
    .reg_wr_index(reg_wr_index)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_at(input int i);
    return reg_out[32*i +: 32];
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] exp_resp, input logic exp_pulse,
                          input logic [IDX_W-1:0] exp_idx, input string tag);
    axi.awaddr = a; axi.awvalid = 1'b1;
    axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
    cyc();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    chk({tag, "_bvalid"}, 32'(axi.bvalid), 32'd1);
    chk({tag, "_bresp"}, 32'(axi.bresp), 32'(exp_resp));
    chk({tag, "_pulse"}, 32'(reg_wr_pulse), 32'(exp_pulse));
    if (exp_pulse) chk({tag, "_index"}, 32'(reg_wr_index), 32'(exp_idx));
    axi.bready = 1'b1;
    cyc();
    axi.bready = 1'b0;
    chk({tag, "_bdone"}, 32'(axi.bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string tag);
    axi.araddr = a; axi.arvalid = 1'b1;
    cyc();
    axi.arvalid = 1'b0;
    chk({tag, "_rvalid"}, 32'(axi.rvalid), 32'd1);
    chk({tag, "_arready"}, 32'(axi.arready), 32'd0);
    chk({tag, "_rdata"}, axi.rdata, exp_data);
    chk({tag, "_rresp"}, 32'(axi.rresp), 32'(exp_resp));
    axi.rready = 1'b1;
    cyc();
    axi.rready = 1'b0;
    chk({tag, "_rdone"}, 32'(axi.rvalid), 32'd0);
  endtask

  initial begin
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

    // Reset state
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_bvalid", 32'(axi.bvalid), 32'd0);
    chk("rst_rvalid", 32'(axi.rvalid), 32'd0);
    chk("rst_awready", 32'(axi.awready), 32'd1);
    chk("rst_wready", 32'(axi.wready), 32'd1);
    chk("rst_arready", 32'(axi.arready), 32'd1);
    chk("rst_bresp", 32'(axi.bresp), 32'd0);
    chk("rst_rresp", 32'(axi.rresp), 32'd0);
    chk("rst_rdata", axi.rdata, 32'd0);
    chk("rst_pulse", 32'(reg_wr_pulse), 32'd0);
    chk("rst_index", 32'(reg_wr_index), 32'd0);
    chk("rst_regs_zero", 32'(reg_out == '0), 32'd1);

    // Single write and readback
    do_write(32'h1008, 32'hDEADBEEF, 4'hF, 2'b00, 1'b1, 4'd2, "wr1");
    chk("wr1_reg2", reg_at(2), 32'hDEADBEEF);
    do_read(32'h1008, 32'hDEADBEEF, 2'b00, "rd1");
    do_read(32'h100B, 32'hDEADBEEF, 2'b00, "rd_lowbits");

    // Split channels: W three cycles ahead of AW
    axi.wdata = 32'h11223344; axi.wstrb = 4'h5; axi.wvalid = 1'b1;
    cyc();
    axi.wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("split_awready", 32'(axi.awready), 32'd1);
      chk("split_wready", 32'(axi.wready), 32'd0);
      chk("split_bvalid", 32'(axi.bvalid), 32'd0);
      cyc();
    end
    chk("split_reg1_pending", reg_at(1), 32'h0);
    axi.awaddr = 32'h1004; axi.awvalid = 1'b1;
    cyc();
    axi.awvalid = 1'b0;
    chk("split_bvalid_on", 32'(axi.bvalid), 32'd1);
    chk("split_pulse", 32'(reg_wr_pulse), 32'd1);
    chk("split_index", 32'(reg_wr_index), 32'd1);
    chk("split_reg1", reg_at(1), 32'h00220044);
    axi.bready = 1'b1;
    cyc();
    axi.bready = 1'b0;

    // Backpressure on B
    axi.awaddr = 32'h1010; axi.awvalid = 1'b1;
    axi.wdata = 32'h12345678; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    cyc();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid", 32'(axi.bvalid), 32'd1);
      chk("bp_bresp", 32'(axi.bresp), 32'd0);
      chk("bp_awready", 32'(axi.awready), 32'd0);
      chk("bp_wready", 32'(axi.wready), 32'd0);
      if (i > 0) chk("bp_pulse_once", 32'(reg_wr_pulse), 32'd0);
      cyc();
    end
    chk("bp_reg4", reg_at(4), 32'h12345678);
    axi.bready = 1'b1;
    axi.awaddr = 32'h1014; axi.awvalid = 1'b1;
    axi.wdata = 32'hAABBCCFF; axi.wstrb = 4'h1; axi.wvalid = 1'b1;
    cyc();
    axi.bready = 1'b0;
    chk("bp_after_bvalid", 32'(axi.bvalid), 32'd0);
    chk("bp_after_awready", 32'(axi.awready), 32'd1);
    chk("bp_after_wready", 32'(axi.wready), 32'd1);
    chk("bp_after_reg5", reg_at(5), 32'h0);
    cyc();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    chk("bp_next_bvalid", 32'(axi.bvalid), 32'd1);
    chk("bp_next_pulse", 32'(reg_wr_pulse), 32'd1);
    chk("bp_next_index", 32'(reg_wr_index), 32'd5);
    chk("bp_next_reg5", reg_at(5), 32'h000000FF);
    axi.bready = 1'b1;
    cyc();
    axi.bready = 1'b0;

    // Read/write collision on register 3
    do_write(32'h100C, 32'hA5A5A5A5, 4'hF, 2'b00, 1'b1, 4'd3, "coll_pre");
    axi.awaddr = 32'h100C; axi.awvalid = 1'b1;
    axi.wdata = 32'h5A5A5A5A; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    axi.araddr = 32'h100C; axi.arvalid = 1'b1;
    cyc();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    chk("coll_rvalid", 32'(axi.rvalid), 32'd1);
    chk("coll_rdata_old", axi.rdata, 32'hA5A5A5A5);
    chk("coll_bvalid", 32'(axi.bvalid), 32'd1);
    chk("coll_reg3_new", reg_at(3), 32'h5A5A5A5A);
    axi.bready = 1'b1; axi.rready = 1'b1;
    cyc();
    axi.bready = 1'b0; axi.rready = 1'b0;
    do_read(32'h100C, 32'h5A5A5A5A, 2'b00, "coll_rd2");

    // Out of range at 0x1040
`ifdef AXI_REG_SLAVE_DECERR_EN
    do_write(32'h1040, 32'hCAFEF00D, 4'hF, 2'b10, 1'b0, 4'd0, "oor_wr");
    chk("oor_reg0", reg_at(0), 32'h0);
    do_read(32'h1040, 32'h0, 2'b10, "oor_rd");
    do_read(32'h0FFC, 32'h0, 2'b10, "below_rd");
`else
    do_write(32'h1040, 32'hCAFEF00D, 4'hF, 2'b00, 1'b1, 4'd0, "oor_wr");
    chk("oor_reg0", reg_at(0), 32'hCAFEF00D);
    do_read(32'h1040, 32'hCAFEF00D, 2'b00, "oor_rd");
    do_read(32'h1000, 32'hCAFEF00D, 2'b00, "oor_rd_base");
`endif
    chk("keep_reg2", reg_at(2), 32'hDEADBEEF);
    chk("keep_reg4", reg_at(4), 32'h12345678);

    // Reset with both responses outstanding
    axi.awaddr = 32'h1018; axi.awvalid = 1'b1;
    axi.wdata = 32'h0BADF00D; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    axi.araddr = 32'h1008; axi.arvalid = 1'b1;
    cyc();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    chk("mid_bvalid", 32'(axi.bvalid), 32'd1);
    chk("mid_rvalid", 32'(axi.rvalid), 32'd1);
    rst = 1'b1;
    cyc();
    chk("mrst_bvalid", 32'(axi.bvalid), 32'd0);
    chk("mrst_rvalid", 32'(axi.rvalid), 32'd0);
    chk("mrst_regs_zero", 32'(reg_out == '0), 32'd1);
    chk("mrst_rdata", axi.rdata, 32'd0);
    chk("mrst_pulse", 32'(reg_wr_pulse), 32'd0);
    rst = 1'b0;
    cyc();
    chk("mrst_awready", 32'(axi.awready), 32'd1);
    chk("mrst_wready", 32'(axi.wready), 32'd1);
    chk("mrst_arready", 32'(axi.arready), 32'd1);
    do_read(32'h1018, 32'h0, 2'b00, "mrst_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
